// File: rtl/led_pwm_driver.sv
// led_pwm_driver: active-low LED pin stage with global PWM dimming and optional blinking.
// Pattern, duty and blink mode are shadowed only on the last cycle of each PWM period,
// so a period always runs to completion with the values it started with.
module led_pwm_driver #(
  parameter int unsigned PWM_W     = 4,
  parameter int unsigned BLINK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pat_n,
  input  logic [PWM_W-1:0] duty,
  input  logic             blink_en,
  output logic [7:0]       out_n,
  output logic             period_start
);

  localparam int unsigned      BlinkW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PWM_W-1:0] CntMax    = '1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [7:0]        pat_q, pat_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic              blink_q, blink_d;
  logic [7:0]        out_n_q, out_n_d;
  logic              period_start_q, period_start_d;
  logic              wrap;
  logic              lit;

  // Next-state: counter, shadow loads at the wrap edge, blink phase, pin drive.
  always_comb begin
    wrap           = (pwm_cnt_q == CntMax);
    pwm_cnt_d      = pwm_cnt_q + 1'b1;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    pat_d          = pat_q;
    duty_d         = duty_q;
    blink_d        = blink_q;
    period_start_d = wrap;

    if (wrap) begin
      pat_d   = pat_n;
      duty_d  = duty;
      blink_d = blink_en;
      // Phase keeps running even with blinking off, so re-enabling stays period-aligned.
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // All-ones duty means fully on; a plain compare would leave one dark cycle.
    lit     = ((duty_q == CntMax) || (pwm_cnt_q < duty_q)) && !(blink_q && blink_phase_q);
    out_n_d = lit ? pat_q : 8'hFF;
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      pat_q          <= 8'hFF;
      duty_q         <= '0;
      blink_q        <= 1'b0;
      out_n_q        <= 8'hFF;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      pat_q          <= pat_d;
      duty_q         <= duty_d;
      blink_q        <= blink_d;
      out_n_q        <= out_n_d;
      period_start_q <= period_start_d;
    end
  end

  assign out_n        = out_n_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver (PWM_W = 4, BLINK_DIV = 2).
// t counts rising edges since the last reset release; edge t evaluates pwm_cnt = (t-1) mod 16
// and wrap edges are t = 16, 32, 48, ...
module tb_led_pwm_driver;

  logic       clk;
  logic       rst;
  logic [7:0] pat_n;
  logic [3:0] duty;
  logic       blink_en;
  logic [7:0] out_n;
  logic       period_start;

  int n_vec;
  int n_err;
  int t_now;

  typedef struct {
    int         t;
    logic [7:0] pat;
    logic [3:0] duty;
    logic       blink;
    logic [7:0] exp_out;
    logic       exp_ps;
  } vec_t;

  vec_t vecs[$];

  led_pwm_driver #(
    .PWM_W    (4),
    .BLINK_DIV(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pat_n       (pat_n),
    .duty        (duty),
    .blink_en    (blink_en),
    .out_n       (out_n),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at t=%0d", t_now);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    t_now++;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    int ps_edge;
    n_vec = 0;
    n_err = 0;
    t_now = 0;

    // Dimming: duty 4 -> 4 lit + 12 dark per period.
    vecs.push_back('{1,   8'hEF, 4'd4,  1'b0, 8'hFF, 1'b0});
    vecs.push_back('{15,  8'hEF, 4'd4,  1'b0, 8'hFF, 1'b0});
    vecs.push_back('{16,  8'hEF, 4'd4,  1'b0, 8'hFF, 1'b1});
    vecs.push_back('{17,  8'hEF, 4'd4,  1'b0, 8'hEF, 1'b0});
    vecs.push_back('{20,  8'hEF, 4'd4,  1'b0, 8'hEF, 1'b0});
    vecs.push_back('{21,  8'hEF, 4'd4,  1'b0, 8'hFF, 1'b0});
    vecs.push_back('{32,  8'hEF, 4'd4,  1'b0, 8'hFF, 1'b1});
    vecs.push_back('{33,  8'hEF, 4'd4,  1'b0, 8'hEF, 1'b0});
    vecs.push_back('{36,  8'hEF, 4'd4,  1'b0, 8'hEF, 1'b0});
    // Mid-period change (applied with pwm_cnt = 6): old values finish the period.
    vecs.push_back('{39,  8'hFB, 4'd12, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{48,  8'hFB, 4'd12, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{49,  8'hFB, 4'd12, 1'b0, 8'hFB, 1'b0});
    vecs.push_back('{60,  8'hFB, 4'd12, 1'b0, 8'hFB, 1'b0});
    vecs.push_back('{61,  8'hFB, 4'd12, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{64,  8'hFB, 4'd12, 1'b0, 8'hFF, 1'b1});
    // Full duty.
    vecs.push_back('{70,  8'hEF, 4'd15, 1'b0, 8'hFB, 1'b0});
    vecs.push_back('{80,  8'hEF, 4'd15, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{81,  8'hEF, 4'd15, 1'b0, 8'hEF, 1'b0});
    vecs.push_back('{96,  8'hEF, 4'd15, 1'b0, 8'hEF, 1'b1});
    vecs.push_back('{97,  8'hEF, 4'd15, 1'b0, 8'hEF, 1'b0});
    // Zero duty.
    vecs.push_back('{100, 8'hEF, 4'd0,  1'b0, 8'hEF, 1'b0});
    vecs.push_back('{112, 8'hEF, 4'd0,  1'b0, 8'hEF, 1'b1});
    vecs.push_back('{113, 8'hEF, 4'd0,  1'b0, 8'hFF, 1'b0});
    vecs.push_back('{128, 8'hEF, 4'd0,  1'b0, 8'hFF, 1'b1});
    // All-ones pattern at full duty stays dark.
    vecs.push_back('{129, 8'hFF, 4'd15, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{145, 8'hFF, 4'd15, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{160, 8'hFF, 4'd15, 1'b0, 8'hFF, 1'b1});
    // Blink: loaded at 176 while phase = 1 -> dark to 192, lit 193..224, dark 225..256.
    vecs.push_back('{161, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{176, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{177, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{192, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{193, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b0});
    vecs.push_back('{224, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b1});
    vecs.push_back('{225, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b0});
    // Blink disabled in the dark phase: lit after wrap 240.
    vecs.push_back('{230, 8'h7F, 4'd15, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{240, 8'h7F, 4'd15, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{241, 8'h7F, 4'd15, 1'b0, 8'h7F, 1'b0});
    // Re-enable: phase kept toggling, so lit 257..288 and dark from 289.
    vecs.push_back('{250, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b0});
    vecs.push_back('{256, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b1});
    vecs.push_back('{257, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b0});
    vecs.push_back('{288, 8'h7F, 4'd15, 1'b1, 8'h7F, 1'b1});
    vecs.push_back('{289, 8'h7F, 4'd15, 1'b1, 8'hFF, 1'b0});
    // Setup for the reset test: duty 8, pattern EF, no blink.
    vecs.push_back('{290, 8'hEF, 4'd8,  1'b0, 8'hFF, 1'b0});
    vecs.push_back('{304, 8'hEF, 4'd8,  1'b0, 8'hFF, 1'b1});
    vecs.push_back('{305, 8'hEF, 4'd8,  1'b0, 8'hEF, 1'b0});
    vecs.push_back('{307, 8'hEF, 4'd8,  1'b0, 8'hEF, 1'b0});

    // Initial reset.
    rst      = 1'b1;
    pat_n    = 8'hEF;
    duty     = 4'd4;
    blink_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("init_rst out_n", out_n, 8'hFF);
    check("init_rst period_start", {7'd0, period_start}, 8'h00);
    rst = 1'b0;

    foreach (vecs[i]) begin
      pat_n    = vecs[i].pat;
      duty     = vecs[i].duty;
      blink_en = vecs[i].blink;
      while (t_now < vecs[i].t) step();
      check($sformatf("vec%0d t=%0d out_n", i, vecs[i].t), out_n, vecs[i].exp_out);
      check($sformatf("vec%0d t=%0d period_start", i, vecs[i].t),
            {7'd0, period_start}, {7'd0, vecs[i].exp_ps});
    end

    // Asynchronous reset mid-period while LEDs are lit.
    rst = 1'b1;
    #1;
    check("async_rst out_n", out_n, 8'hFF);
    check("async_rst period_start", {7'd0, period_start}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_hold%0d out_n", k), out_n, 8'hFF);
      check($sformatf("rst_hold%0d period_start", k), {7'd0, period_start}, 8'h00);
    end
    rst   = 1'b0;
    t_now = 0;

    // First period_start must follow the 16th edge after release.
    ps_edge = 0;
    while (ps_edge == 0 && t_now < 40) begin
      step();
      if (period_start) ps_edge = t_now;
      else check($sformatf("post_rst t=%0d out_n", t_now), out_n, 8'hFF);
    end
    check("first period_start edge", 8'(ps_edge), 8'd16);
    step();
    check("post_rst first lit out_n", out_n, 8'hEF);
    check("post_rst period_start low", {7'd0, period_start}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Output stage downstream of the 3-to-8 switch decoder: consumes its registered active-low 8-bit LED pattern and drives the board LED pins with global PWM dimming and optional blinking. It double-buffers pattern, duty and blink mode at PWM period boundaries so the pins never glitch mid-period. All pin drive is active-low (0 = LED lit), matching the decoder output convention.

## Interface

- PWM_W, 4, PWM counter/duty width; period = 2^PWM_W cycles.
- BLINK_DIV, 2, PWM periods per blink half-phase; must be ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pat_n  in  8  active-low LED pattern from the decoder stage.
- duty  in  PWM_W  brightness; 0 = off, all-ones = 100 % on.
- blink_en  in  1  1 = blink enabled.
- out_n  out  8  registered active-low LED pin drive.
- period_start  out  1  one-cycle pulse when shadow registers load.

## Operation

- pwm_cnt: free-running PWM_W-bit counter, increments every clk, wraps MAX = 2^PWM_W-1 → 0.
- Wrap edge: a clk edge at which pwm_cnt == MAX. On that edge:
  - pat_q ← pat_n, duty_q ← duty, blink_q ← blink_en;
  - period_start ← 1; it is 0 on every other edge;
  - blink counter advances.
- Inputs are sampled only on wrap edges; changes at any other time have no effect until the next wrap edge.
- Blink counter blink_cnt (0..BLINK_DIV-1), advancing on each wrap edge:
  - at BLINK_DIV-1 it returns to 0 and blink_phase toggles; otherwise it increments.
  - blink_phase runs even when blink_q = 0.
- on = (duty_q == MAX or pwm_cnt < duty_q) and not (blink_q and blink_phase). All terms use pre-edge register values.
- Every edge: out_n ← on ? pat_q : 8'hFF.
  - pat_q bits pass through unmodified, so multi-bit or all-ones patterns are legal.
- Reset values: pwm_cnt 0, blink_cnt 0, blink_phase 0, pat_q 8'hFF, duty_q 0, blink_q 0, out_n 8'hFF, period_start 0.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronously) and out_n is 8'hFF while rst is high.
- After reset release, the first wrap edge is the 2^PWM_W-th rising edge.

## Timing

- Latency: inputs stable before wrap edge E take effect on out_n from edge E+1.
  - At edge E+1, pwm_cnt = 0 is evaluated.
- Each PWM period, out_n holds pat_q for duty_q cycles, then 8'hFF for the remaining 2^PWM_W − duty_q cycles.
  - Exception, duty_q == MAX: pat_q for the full period.
  - Exception, duty_q == 0: 8'hFF for the full period.
- Period, counted from the first out_n update after a wrap edge: 2^PWM_W cycles.
- Blink with blink_q = 1: LEDs dark for BLINK_DIV full periods, then lit (PWM) for BLINK_DIV full periods, repeating.
  - Phase boundaries are aligned to period boundaries.
- period_start is high for exactly one cycle, in the cycle after each wrap edge, i.e. every 2^PWM_W cycles.
- Simultaneous duty change and pattern change: both take effect together on the same wrap edge, never one period apart.

## Test plan

(All scenarios use PWM_W = 4, BLINK_DIV = 2.)

- Reset: rst pulsed for 3 cycles mid-period with pat_n = 8'hEF, duty = 8 → out_n = 8'hFF and period_start = 0 during rst. The first period_start occurs at the 16th edge after release.
- Dimming: pat_n = 8'hEF, duty = 4, blink_en = 0 held → each period is 4 cycles of 8'hEF then 12 cycles of 8'hFF; period_start every 16 cycles.
- Extremes:
  - duty = 15 → out_n constantly 8'hEF across periods;
  - duty = 0 → constantly 8'hFF;
  - pat_n = 8'hFF, duty = 15 → 8'hFF.
- Mid-period change: duty switched 4 → 12 and pat_n switched 8'hEF → 8'hFB at pwm_cnt = 6 → the current period completes with the old values (8'hEF for 4 cycles). The next period shows 8'hFB for 12 cycles.
- Blink: pat_n = 8'h7F, duty = 15, blink_en = 1 → out_n alternates 8'hFF for 32 cycles and 8'h7F for 32 cycles, starting in the dark phase if blink_phase = 1 at the load.
- Blink disable: blink_en dropped during a dark phase → LEDs lit from the first period after the next wrap edge; blink_phase keeps toggling internally.
